// File: rtl/univ_shift_pkg.sv
// Shared types and mode encodings for the universal shift register.
// Imported by the RTL and by the bench so both use the same codes.
package univ_shift_pkg;

    typedef enum logic [2:0] {
        M_HOLD  = 3'b000,
        M_SHR   = 3'b001,
        M_SHL   = 3'b010,
        M_LOAD  = 3'b011,
        M_ROR   = 3'b100,
        M_ROL   = 3'b101,
        M_ASR   = 3'b110,
        M_CLEAR = 3'b111
    } usr_mode_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } usr_state_e;

    localparam logic [2:0] MODE_HOLD  = 3'b000;
    localparam logic [2:0] MODE_SHR   = 3'b001;
    localparam logic [2:0] MODE_SHL   = 3'b010;
    localparam logic [2:0] MODE_LOAD  = 3'b011;
    localparam logic [2:0] MODE_ROR   = 3'b100;
    localparam logic [2:0] MODE_ROL   = 3'b101;
    localparam logic [2:0] MODE_ASR   = 3'b110;
    localparam logic [2:0] MODE_CLEAR = 3'b111;

    // Modes whose count comes from cmd_amt; the rest always take one edge.
    function automatic logic is_shift(input logic [2:0] m);
        return (m == MODE_SHR) || (m == MODE_SHL) || (m == MODE_ROR)
            || (m == MODE_ROL) || (m == MODE_ASR);
    endfunction

endpackage

// File: rtl/univ_shift_reg_n_step.sv
// Single-step next-state function of the universal shift register.
// Purely combinational; the top decides which mode to feed it.
module usr_shift_step
    import univ_shift_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] q,
    input  logic             ser_in_r,
    input  logic             ser_in_l,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] nxt
);

    always_comb begin
        nxt = q;
        case (usr_mode_e'(mode))
            M_HOLD:  nxt = q;
            M_SHR:   nxt = {ser_in_r, q[WIDTH-1:1]};
            M_SHL:   nxt = {q[WIDTH-2:0], ser_in_l};
            M_LOAD:  nxt = d;
            M_ROR:   nxt = {q[0], q[WIDTH-1:1]};
            M_ROL:   nxt = {q[WIDTH-2:0], q[WIDTH-1]};
            M_ASR:   nxt = {q[WIDTH-1], q[WIDTH-1:1]};
            M_CLEAR: nxt = '0;
        endcase
    end

endmodule

// File: rtl/univ_shift_reg_n.sv
// Command-driven universal shift register: one bit per clock,
// valid/ready command intake, one-cycle done pulse on completion.
module univ_shift_reg_n
    import univ_shift_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_mode,
    input  logic [CNT_W-1:0] cmd_amt,
    input  logic [WIDTH-1:0] d,
    input  logic             ser_in_r,
    input  logic             ser_in_l,
    output logic [WIDTH-1:0] q,
    output logic             ser_out_r,
    output logic             ser_out_l,
    output logic             busy,
    output logic             done
);

    localparam logic [CNT_W-1:0] AMT_MAX = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    usr_state_e       state;
    logic [2:0]       mode_r;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] amt_c;
    logic [2:0]       mode0;
    logic [2:0]       step_mode;
    logic [WIDTH-1:0] nxt;
    logic             accept;
    logic             multi;

    // A zero-count shift degenerates to a single HOLD edge.
    always_comb begin
        amt_c = (cmd_amt > AMT_MAX) ? AMT_MAX : cmd_amt;
        mode0 = cmd_mode;
        if (is_shift(cmd_mode) && (amt_c == '0))
            mode0 = MODE_HOLD;
        multi     = is_shift(cmd_mode) && (amt_c > ONE);
        step_mode = (state == S_RUN) ? mode_r : mode0;
    end

    assign cmd_ready = (state == S_IDLE) && !rst;
    assign accept    = cmd_valid && cmd_ready;
    assign busy      = (state == S_RUN);
    assign ser_out_r = q[0];
    assign ser_out_l = q[WIDTH-1];

    usr_shift_step #(.WIDTH(WIDTH)) u_step (
        .mode     (step_mode),
        .q        (q),
        .ser_in_r (ser_in_r),
        .ser_in_l (ser_in_l),
        .d        (d),
        .nxt      (nxt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            q      <= '0;
            mode_r <= MODE_HOLD;
            cnt    <= '0;
            done   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= accept && !multi;
                    if (accept) begin
                        q <= nxt;
                        if (multi) begin
                            mode_r <= cmd_mode;
                            cnt    <= amt_c - ONE;
                            state  <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    q   <= nxt;
                    cnt <= cnt - ONE;
                    if (cnt == ONE) begin
                        state <= S_IDLE;
                        done  <= 1'b1;
                    end else begin
                        done <= 1'b0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_univ_shift_reg_n.sv
// Bench for univ_shift_reg_n: directed scenarios plus random traffic,
// all checked every cycle against an arithmetic model of the register.
module tb_univ_shift_reg_n;
    import univ_shift_pkg::*;

    localparam int W  = 8;
    localparam int CW = $clog2(W + 1);
    localparam int H  = 1 << (W - 1);
    localparam int F  = 1 << W;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [2:0]    cmd_mode = 3'b000;
    logic [CW-1:0] cmd_amt = '0;
    logic [W-1:0]  d = '0;
    logic          ser_in_r = 1'b0;
    logic          ser_in_l = 1'b0;
    logic [W-1:0]  q;
    logic          ser_out_r;
    logic          ser_out_l;
    logic          busy;
    logic          done;

    univ_shift_reg_n #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_mode  (cmd_mode),
        .cmd_amt   (cmd_amt),
        .d         (d),
        .ser_in_r  (ser_in_r),
        .ser_in_l  (ser_in_l),
        .q         (q),
        .ser_out_r (ser_out_r),
        .ser_out_l (ser_out_l),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Model state: register value, edges still owed, latched mode, done.
    int m_q    = 0;
    int m_rem  = 0;
    int m_mode = 0;
    int m_done = 0;

    function automatic int apply(int mode, int v, int sr, int sl, int dv);
        case (mode)
            0:       return v;
            1:       return v / 2 + sr * H;
            2:       return (v * 2) % F + sl;
            3:       return dv;
            4:       return v / 2 + (v % 2) * H;
            5:       return (v * 2) % F + v / H;
            6:       return v / 2 + (v / H) * H;
            default: return 0;
        endcase
    endfunction

    task automatic cmp(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic check();
        cmp("q", 32'(q), 32'(m_q));
        cmp("busy", 32'(busy), 32'(m_rem > 0));
        cmp("done", 32'(done), 32'(m_done));
        cmp("cmd_ready", 32'(cmd_ready), 32'(m_rem == 0 && !rst));
        cmp("ser_out_r", 32'(ser_out_r), 32'(m_q % 2));
        cmp("ser_out_l", 32'(ser_out_l), 32'(m_q / H));
    endtask

    task automatic cycle();
        int nq, nrem, nmode, ndone, amt, steps, emode;
        bit sh;
        nq = m_q; nrem = m_rem; nmode = m_mode; ndone = 0;
        if (rst) begin
            nq = 0; nrem = 0;
        end else if (m_rem > 0) begin
            nq    = apply(m_mode, m_q, int'(ser_in_r), int'(ser_in_l), int'(d));
            nrem  = m_rem - 1;
            ndone = (nrem == 0);
        end else if (cmd_valid) begin
            amt   = (int'(cmd_amt) > W) ? W : int'(cmd_amt);
            sh    = cmd_mode inside {3'd1, 3'd2, 3'd4, 3'd5, 3'd6};
            steps = (sh && amt > 0) ? amt : 1;
            emode = (sh && amt == 0) ? 0 : int'(cmd_mode);
            nq    = apply(emode, m_q, int'(ser_in_r), int'(ser_in_l), int'(d));
            nrem  = steps - 1;
            nmode = int'(cmd_mode);
            ndone = (steps == 1);
        end
        @(posedge clk);
        #1;
        m_q = nq; m_rem = nrem; m_mode = nmode; m_done = ndone;
        check();
    endtask

    task automatic set_rst(bit v);
        rst = v;
        if (v) begin
            m_q = 0; m_rem = 0; m_done = 0;
        end
        #1;
        check();
    endtask

    task automatic issue(logic [2:0] mode, int amt, logic [W-1:0] dv);
        cmd_valid = 1'b1;
        cmd_mode  = mode;
        cmd_amt   = CW'(amt);
        d         = dv;
        cycle();
        cmd_valid = 1'b0;
    endtask

    initial begin
        #1;
        set_rst(1'b1);
        cmp("reset_q", 32'(q), 32'h00);
        cycle();
        cycle();
        @(negedge clk);
        set_rst(1'b0);
        cmp("ready_after_reset", 32'(cmd_ready), 32'h1);
        cycle();

        issue(MODE_LOAD, 0, 8'hA5);
        cmp("load_q", 32'(q), 32'hA5);
        cmp("load_done", 32'(done), 32'h1);
        cycle();

        ser_in_r = 1'b1;
        issue(MODE_SHR, 3, 8'h00);
        cmp("shr_e0", 32'(q), 32'hD2);
        cmp("shr_ready_e0", 32'(cmd_ready), 32'h0);
        cycle();
        cmp("shr_e1", 32'(q), 32'hE9);
        cmp("shr_ready_e1", 32'(cmd_ready), 32'h0);
        cycle();
        cmp("shr_e2", 32'(q), 32'hF4);
        cmp("shr_done", 32'(done), 32'h1);
        cycle();

        issue(MODE_LOAD, 0, 8'h81);
        issue(MODE_ROL, 8, 8'h00);
        repeat (7) cycle();
        cmp("rol8_q", 32'(q), 32'h81);
        cmp("rol8_done", 32'(done), 32'h1);

        issue(MODE_LOAD, 0, 8'h81);
        issue(MODE_ROR, 1, 8'h00);
        cmp("ror1_q", 32'(q), 32'hC0);

        issue(MODE_LOAD, 0, 8'h90);
        issue(MODE_ASR, 2, 8'h00);
        cycle();
        cmp("asr2_q", 32'(q), 32'hE4);

        // Clamped SHL with the next command already waiting on cmd_valid.
        issue(MODE_LOAD, 0, 8'hFF);
        ser_in_l  = 1'b0;
        cmd_valid = 1'b1;
        cmd_mode  = MODE_SHL;
        cmd_amt   = CW'(12);
        cycle();
        cmd_mode = MODE_LOAD;
        d        = 8'h5A;
        repeat (6) cycle();
        cmp("shl_not_done_yet", 32'(done), 32'h0);
        cycle();
        cmp("shl12_q", 32'(q), 32'h00);
        cmp("shl12_done", 32'(done), 32'h1);
        cmp("shl12_ready", 32'(cmd_ready), 32'h1);
        cycle();
        cmp("held_load_q", 32'(q), 32'h5A);
        cmd_valid = 1'b0;

        issue(MODE_LOAD, 0, 8'hFF);
        ser_in_r = 1'b0;
        issue(MODE_SHR, 5, 8'h00);
        cycle();
        cmp("shr5_step2", 32'(q), 32'h3F);
        @(negedge clk);
        set_rst(1'b1);
        cmp("abort_q", 32'(q), 32'h00);
        cycle();
        cmp("abort_no_done", 32'(done), 32'h0);
        @(negedge clk);
        set_rst(1'b0);
        cycle();
        cmp("abort_no_done2", 32'(done), 32'h0);
        issue(MODE_LOAD, 0, 8'h3C);
        cmp("post_abort_load", 32'(q), 32'h3C);
        cmp("post_abort_done", 32'(done), 32'h1);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                set_rst(1'b1);
                cycle();
                set_rst(1'b0);
            end else begin
                cmd_valid = ($urandom_range(0, 9) < 6);
                cmd_mode  = 3'($urandom_range(0, 7));
                cmd_amt   = CW'($urandom_range(0, (1 << CW) - 1));
                d         = W'($urandom);
                ser_in_r  = 1'($urandom_range(0, 1));
                ser_in_l  = 1'($urandom_range(0, 1));
                cycle();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
